bcd_to_sseg: RTL and testbench
==============================

Name: bcd_to_sseg

Overview:
Registered BCD-to-seven-segment decoder for a single display digit. It takes a 4-bit BCD/hex nibble and drives seven segment lines a..g, with one clock of latency. It sits between the digit-multiplexing/counter logic and the board's seven-segment display pins. It also provides blanking, lamp test and selectable output polarity.

Parameters:
ACTIVE_LOW, 1, 1 = segment ON drives 0 (common-anode board); 0 = segment ON drives 1.
HEX_EN, 0, 0 = codes 10..15 display blank; 1 = codes 10..15 display A b C d E F.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  update enable; 0 = hold the current SSeg value.
blank  input  1  1 = all segments off (leading-zero suppression).
lamp_test  input  1  1 = all segments on.
inBCD  input  4  digit code, 0..9 (10..15 handled per HEX_EN).
SSeg  output  7  registered segment drive; SSeg[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- SSeg is a register with no combinational path from inputs to output. Latency is 1 clock: the value sampled at edge N appears after edge N.
- Reset:
  - rst=1 at a rising edge loads "all segments off". That is 7'h7F when ACTIVE_LOW=1 and 7'h00 when ACTIVE_LOW=0.
  - Reset overrides en, lamp_test and blank.
  - Reset asserted mid-operation takes effect at the next edge regardless of the prior value.
- Priority at each edge with rst=0 and en=1: lamp_test > blank > decode.
  - lamp_test=1: all segments on.
  - blank=1 with lamp_test=0: all segments off.
  - Otherwise: the decode table below.
- en=0 with rst=0: SSeg holds its value. lamp_test and blank are also ignored while en=0.
- Decode table, active-high pattern g..a (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - HEX_EN=1: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - HEX_EN=0: codes 10..15 = 00 (blank). This is not an error condition and raises no flag.
- ACTIVE_LOW=1: the output is the bitwise inverse of the active-high pattern. For example, 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
- No X propagation: every case, including default, assigns all 7 bits.

Test Plan:
- Reset: hold rst=1 for 2 edges with inBCD=8 and lamp_test=1 → SSeg=7F (ACTIVE_LOW=1). Release rst, en=1, lamp_test=0 → SSeg=00 one edge later.
- Digit sweep, ACTIVE_LOW=1, en=1: apply inBCD 0..9, one per clock → SSeg = 40,79,24,30,19,12,02,78,00,10, each one clock after its input.
- Out-of-range codes: inBCD 10..15 → SSeg=7F with HEX_EN=0. With HEX_EN=1 and ACTIVE_LOW=0 → 77,7C,39,5E,79,71.
- Priority, ACTIVE_LOW=0, inBCD=3:
  - blank=1 → 00.
  - blank=1 and lamp_test=1 → 7F.
  - Both low → 4F.
- Hold: load inBCD=5 (SSeg=12, ACTIVE_LOW=1). Set en=0 and change inBCD to 1 and blank to 1 over 3 clocks → SSeg stays 12. Raise en → SSeg=7F next edge.
- Latency check: change inBCD between edges → SSeg changes only at the following rising edge, never mid-cycle.

Source files
------------

// File: rtl/bcd_to_sseg.sv
// Registered BCD/hex to seven-segment decoder, one digit.
// Lamp test and blanking, selectable output polarity.
module bcd_to_sseg #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic [3:0] inBCD,
  output logic [6:0] SSeg
);

  localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] pat;
  logic [6:0] hi;
  logic [6:0] nxt;

  // Active-high pattern, bit order g..a
  always_comb begin
    pat = 7'h00;
    case (inBCD)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = HEX_EN ? 7'h77 : 7'h00;
      4'hB:    pat = HEX_EN ? 7'h7C : 7'h00;
      4'hC:    pat = HEX_EN ? 7'h39 : 7'h00;
      4'hD:    pat = HEX_EN ? 7'h5E : 7'h00;
      4'hE:    pat = HEX_EN ? 7'h79 : 7'h00;
      4'hF:    pat = HEX_EN ? 7'h71 : 7'h00;
      default: pat = 7'h00;
    endcase
  end

  always_comb begin
    hi = pat;
    unique case (1'b1)
      lamp_test:           hi = 7'h7F;
      !lamp_test && blank: hi = 7'h00;
      !lamp_test && !blank: hi = pat;
    endcase
    nxt = ACTIVE_LOW ? ~hi : hi;
  end

  always_ff @(posedge clk) begin
    if (rst)
      SSeg <= OFF;
    else if (en)
      SSeg <= nxt;
  end

endmodule

// File: tb/tb_bcd_to_sseg.sv
// Bench for bcd_to_sseg: directed vector table, latency check,
// and randomized run against a segment-letter reference model.
module tb_bcd_to_sseg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [3:0] inBCD = 4'd0;
  logic [6:0] s0, s1, s2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // s0: common anode, blank hex; s1: common cathode, hex; s2: anode, hex
  bcd_to_sseg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .blank(blank),
    .lamp_test(lamp_test), .inBCD(inBCD), .SSeg(s0));
  bcd_to_sseg #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .blank(blank),
    .lamp_test(lamp_test), .inBCD(inBCD), .SSeg(s1));
  bcd_to_sseg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .blank(blank),
    .lamp_test(lamp_test), .inBCD(inBCD), .SSeg(s2));

  // Lit segments per glyph, letters a..g
  string segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
    "acdefg", "abc", "abcdefg", "abcdfg",
    "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(int code, bit hx);
    logic [6:0] m;
    string s;
    m = 7'h00;
    if (code > 9 && !hx) return m;
    s = segs[code];
    for (int i = 0; i < s.len(); i++)
      m[s[i] - "a"] = 1'b1;
    return m;
  endfunction

  function automatic logic [6:0] ref_seg(
    bit al, bit hx, logic [6:0] prev,
    bit r, bit e, bit b, bit l, int code);
    logic [6:0] on;
    if (r) return al ? 7'h7F : 7'h00;
    if (!e) return prev;
    if (l) on = 7'h7F;
    else if (b) on = 7'h00;
    else on = glyph(code, hx);
    return al ? ~on : on;
  endfunction

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r;
    bit         e;
    bit         b;
    bit         l;
    logic [3:0] code;
    logic [6:0] x0;
    logic [6:0] x1;
  } vec_t;

  vec_t v[$];
  logic [6:0] m0, m1, m2;

  initial begin
    // reset with lamp test and 8 applied
    v.push_back('{1, 0, 0, 1, 8, 7'h7F, 7'h00});
    v.push_back('{1, 0, 0, 1, 8, 7'h7F, 7'h00});
    v.push_back('{0, 1, 0, 0, 8, 7'h00, 7'h7F});
    // digit sweep
    v.push_back('{0, 1, 0, 0, 0, 7'h40, 7'h3F});
    v.push_back('{0, 1, 0, 0, 1, 7'h79, 7'h06});
    v.push_back('{0, 1, 0, 0, 2, 7'h24, 7'h5B});
    v.push_back('{0, 1, 0, 0, 3, 7'h30, 7'h4F});
    v.push_back('{0, 1, 0, 0, 4, 7'h19, 7'h66});
    v.push_back('{0, 1, 0, 0, 5, 7'h12, 7'h6D});
    v.push_back('{0, 1, 0, 0, 6, 7'h02, 7'h7D});
    v.push_back('{0, 1, 0, 0, 7, 7'h78, 7'h07});
    v.push_back('{0, 1, 0, 0, 8, 7'h00, 7'h7F});
    v.push_back('{0, 1, 0, 0, 9, 7'h10, 7'h6F});
    // codes 10..15
    v.push_back('{0, 1, 0, 0, 10, 7'h7F, 7'h77});
    v.push_back('{0, 1, 0, 0, 11, 7'h7F, 7'h7C});
    v.push_back('{0, 1, 0, 0, 12, 7'h7F, 7'h39});
    v.push_back('{0, 1, 0, 0, 13, 7'h7F, 7'h5E});
    v.push_back('{0, 1, 0, 0, 14, 7'h7F, 7'h79});
    v.push_back('{0, 1, 0, 0, 15, 7'h7F, 7'h71});
    // priority on code 3
    v.push_back('{0, 1, 1, 0, 3, 7'h7F, 7'h00});
    v.push_back('{0, 1, 1, 1, 3, 7'h00, 7'h7F});
    v.push_back('{0, 1, 0, 0, 3, 7'h30, 7'h4F});
    // hold while en low
    v.push_back('{0, 1, 0, 0, 5, 7'h12, 7'h6D});
    v.push_back('{0, 0, 0, 0, 1, 7'h12, 7'h6D});
    v.push_back('{0, 0, 1, 0, 1, 7'h12, 7'h6D});
    v.push_back('{0, 0, 1, 1, 1, 7'h12, 7'h6D});
    v.push_back('{0, 1, 1, 0, 1, 7'h7F, 7'h00});
    // reset mid-operation beats lamp test
    v.push_back('{0, 1, 0, 0, 8, 7'h00, 7'h7F});
    v.push_back('{1, 1, 0, 1, 8, 7'h7F, 7'h00});

    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r;
      en = v[i].e;
      blank = v[i].b;
      lamp_test = v[i].l;
      inBCD = v[i].code;
      step();
      chk($sformatf("vec%0d_al", i), s0, v[i].x0);
      chk($sformatf("vec%0d_ah", i), s1, v[i].x1);
    end

    // latency: mid-cycle input change must not reach the output
    rst = 0; en = 1; blank = 0; lamp_test = 0; inBCD = 4'd0;
    step();
    chk("lat_load", s0, 7'h40);
    inBCD = 4'd1;
    #3;
    chk("lat_mid_al", s0, 7'h40);
    chk("lat_mid_ah", s1, 7'h3F);
    step();
    chk("lat_after", s0, 7'h79);

    // randomized run, first cycle forced into reset
    m0 = 'x; m1 = 'x; m2 = 'x;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom % 16 == 0);
      en = ($urandom % 4) != 0;
      blank = ($urandom % 4) == 0;
      lamp_test = ($urandom % 8) == 0;
      inBCD = 4'($urandom % 16);
      m0 = ref_seg(1, 0, m0, rst, en, blank, lamp_test, int'(inBCD));
      m1 = ref_seg(0, 1, m1, rst, en, blank, lamp_test, int'(inBCD));
      m2 = ref_seg(1, 1, m2, rst, en, blank, lamp_test, int'(inBCD));
      step();
      chk($sformatf("rnd%0d_u0", i), s0, m0);
      chk($sformatf("rnd%0d_u1", i), s1, m1);
      chk($sformatf("rnd%0d_u2", i), s2, m2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
